// File: rtl/count_req_scheduler.sv
// count_req_scheduler
//   Round-robin scheduler that shares one WIDTH-bit up/down counter between
//   NREQ requesters. Each requester asks for a single +1 or -1 step. One
//   request is granted per three-cycle slot (IDLE -> ISSUE -> SETTLE). A step
//   that would wrap the counter is refused (NACKed), and the counter is left
//   untouched.
//
// Ports
//   clk       in   1      clock, rising edge
//   reset     in   1      synchronous, active-low reset
//   req       in   NREQ   per-requester step request, level, held until gnt
//   dir       in   NREQ   per-requester direction: 1 = up, 0 = down
//   count_in  in   WIDTH  current value of the shared counter
//   gnt       out  NREQ   one-hot 1-cycle pulse: request consumed
//   nack      out  1      with gnt: step refused (saturation)
//   enable    out  1      to counter: step enable
//   up_en     out  1      to counter: count up
//   down_en   out  1      to counter: count down
//   busy      out  1      high in ISSUE and SETTLE
//
// All outputs are registered.

module count_req_scheduler #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [NREQ-1:0]  req,
   input  logic [NREQ-1:0]  dir,
   input  logic [WIDTH-1:0] count_in,
   output logic [NREQ-1:0]  gnt,
   output logic             nack,
   output logic             enable,
   output logic             up_en,
   output logic             down_en,
   output logic             busy
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [WIDTH-1:0] MAXV = {WIDTH{1'b1}};

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ISSUE  = 2'd1;
   localparam logic [1:0] S_SETTLE = 2'd2;

   logic [1:0]    state;
   logic [PW-1:0] ptr;
   logic [PW-1:0] win;

   logic          sel_found;
   logic [PW-1:0] sel_idx;
   logic          sel_dir;
   logic          sel_sat;
   logic [PW:0]   scan_sum;
   logic [PW-1:0] scan_idx;

   // Round-robin search: the first asserted request found when scanning
   // upward from ptr, wrapping at NREQ. One extra bit on the sum keeps
   // ptr+i from overflowing before the modulo-NREQ correction.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      scan_sum  = '0;
      scan_idx  = '0;
      for (int i = 0; i < NREQ; i++) begin
         scan_sum = {1'b0, ptr} + (PW+1)'(i);
         if (scan_sum >= (PW+1)'(NREQ)) begin
            scan_sum = scan_sum - (PW+1)'(NREQ);
         end
         scan_idx = scan_sum[PW-1:0];
         if (!sel_found && req[scan_idx]) begin
            sel_found = 1'b1;
            sel_idx   = scan_idx;
         end
      end
      sel_dir = dir[sel_idx];
      sel_sat = sel_dir ? (count_in == MAXV) : (count_in == '0);
   end

   // The winner, its direction and the saturation verdict are captured at the
   // arbitration edge directly into the output strobes. The strobes are then
   // high for exactly the ISSUE cycle. The pointer advances when ISSUE ends,
   // so a reset during ISSUE leaves the pointer at zero.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state   <= S_IDLE;
         ptr     <= '0;
         win     <= '0;
         gnt     <= '0;
         nack    <= 1'b0;
         enable  <= 1'b0;
         up_en   <= 1'b0;
         down_en <= 1'b0;
         busy    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (sel_found) begin
                  win     <= sel_idx;
                  gnt     <= NREQ'(1) << sel_idx;
                  nack    <= sel_sat;
                  enable  <= ~sel_sat;
                  up_en   <= ~sel_sat & sel_dir;
                  down_en <= ~sel_sat & ~sel_dir;
                  busy    <= 1'b1;
                  state   <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               gnt     <= '0;
               nack    <= 1'b0;
               enable  <= 1'b0;
               up_en   <= 1'b0;
               down_en <= 1'b0;
               ptr     <= (win == PW'(NREQ-1)) ? '0 : win + 1'b1;
               state   <= S_SETTLE;
            end
            S_SETTLE: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               gnt     <= '0;
               nack    <= 1'b0;
               enable  <= 1'b0;
               up_en   <= 1'b0;
               down_en <= 1'b0;
               busy    <= 1'b0;
               state   <= S_IDLE;
            end
         endcase
      end
   end

endmodule
